pc_target_unit: RTL and testbench

- Next-generation branch-target block for the fetch stage: a programmable table of N branch targets plus the PC register that consumes them.
- Each entry holds a D-bit target and a mode bit: relative (PC + offset, mod 2^D) or absolute (PC = target).
- A small run-control FSM (IDLE/RUN/HALTED) steps the PC; table entries can be rewritten at any time through a config port.

---
 rtl/pc_target_unit.sv | 165 ++++++++++++++++
 tb/tb_pc_target_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_target_unit.sv
// Fetch-stage branch-target table plus PC register with IDLE/RUN/HALTED run control.
// Optional taken-branch counter enabled by defining PC_TARGET_BRANCH_COUNT_EN.
module pc_target_unit #(
    parameter int          D        = 12,
    parameter int          N        = 8,
    parameter int unsigned RESET_PC = 0,
    localparam int         IW       = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          halt,
    input  logic          advance,
    input  logic          branch_en,
    input  logic [IW-1:0] how_high,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [D-1:0]  cfg_data,
    input  logic          cfg_abs,
    output logic [D-1:0]  pc_out,
    output logic          running,
    output logic          done,
    output logic          bad_idx,
    output logic [15:0]   taken_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    // Table is sized to the full index space; entries at or above N are never written or read.
    localparam int             TBL    = 1 << IW;
    localparam logic [IW:0]    N_LIM  = (IW + 1)'(N);
    localparam logic [D-1:0]   PC_RST = D'(RESET_PC);

    function automatic logic [D-1:0] init_tgt(input int i);
        case (i)
            0:       return D'(2);
            1:       return D'(4);
            2:       return D'(22);
            3:       return D'(-26);
            4:       return D'(130);
            5:       return D'(-132);
            6:       return D'(162);
            7:       return D'(-168);
            default: return '0;
        endcase
    endfunction

    state_t       state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic         bad_q, bad_d;
    logic [D-1:0] tgt_q [TBL];
    logic [D-1:0] tgt_d [TBL];
    logic         abs_q [TBL];
    logic         abs_d [TBL];
    logic         br_idx_ok;
    logic         cfg_idx_ok;
    logic         restart;
    logic         step_en;

    assign br_idx_ok  = {1'b0, how_high} < N_LIM;
    assign cfg_idx_ok = {1'b0, cfg_idx} < N_LIM;
    assign restart    = start && (state_q != S_RUN);
    assign step_en    = (state_q == S_RUN) && !halt && advance;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_RUN;
            S_RUN:    if (halt)  state_d = S_HALTED;
            S_HALTED: if (start) state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == S_RUN);
        done    = (state_q == S_HALTED);
    end

    // Branch resolution reads the registered table, so a same-cycle write is seen only next cycle.
    always_comb begin
        pc_d  = pc_q;
        bad_d = bad_q;
        if (restart) begin
            pc_d  = PC_RST;
            bad_d = 1'b0;
        end else if (step_en) begin
            if (!branch_en) begin
                pc_d = pc_q + D'(1);
            end else if (br_idx_ok) begin
                pc_d = abs_q[how_high] ? tgt_q[how_high] : pc_q + tgt_q[how_high];
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q  <= PC_RST;
            bad_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            bad_q <= bad_d;
        end
    end

    always_comb begin
        tgt_d = tgt_q;
        abs_d = abs_q;
        if (cfg_we && cfg_idx_ok) begin
            tgt_d[cfg_idx] = cfg_data;
            abs_d[cfg_idx] = cfg_abs;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < TBL; i++) begin
                tgt_q[i] <= (i < N) ? init_tgt(i) : '0;
                abs_q[i] <= 1'b0;
            end
        end else begin
            tgt_q <= tgt_d;
            abs_q <= abs_d;
        end
    end

    assign pc_out  = pc_q;
    assign bad_idx = bad_q;

`ifdef PC_TARGET_BRANCH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (step_en && branch_en && br_idx_ok && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign taken_cnt = cnt_q;
`else
    assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_target_unit.sv
// Bench for pc_target_unit: an N=8 and an N=6 instance share stimulus and are
// compared each cycle against a behavioural model, plus directed scenario checks.
module tb_pc_target_unit;

    localparam int D   = 12;
    localparam int MOD = 4096;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
`ifdef PC_TARGET_BRANCH_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0, halt = 1'b0, advance = 1'b0, branch_en = 1'b0;
    logic [2:0]    how_high = '0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = '0;
    logic [D-1:0]  cfg_data = '0;
    logic          cfg_abs = 1'b0;

    logic [D-1:0]  pc8, pc6;
    logic          run8, run6, done8, done6, bad8, bad6;
    logic [15:0]   cnt8, cnt6;

    pc_target_unit #(.D(D), .N(8)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .halt(halt), .advance(advance),
        .branch_en(branch_en), .how_high(how_high), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_abs(cfg_abs), .pc_out(pc8), .running(run8),
        .done(done8), .bad_idx(bad8), .taken_cnt(cnt8)
    );

    pc_target_unit #(.D(D), .N(6)) dut6 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .halt(halt), .advance(advance),
        .branch_en(branch_en), .how_high(how_high), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_abs(cfg_abs), .pc_out(pc6), .running(run6),
        .done(done6), .bad_idx(bad6), .taken_cnt(cnt6)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference model: per-instance PC, mode, flags and table as plain integers.
    int m_n [2] = '{8, 6};
    int m_st [2];
    int m_pc [2];
    int m_bad [2];
    int m_cnt [2];
    int m_tgt [2][8];
    bit m_abs [2][8];
    int INIT_T [8] = '{2, 4, 22, -26, 130, -132, 162, -168};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_pc[k] = 0; m_bad[k] = 0; m_cnt[k] = 0;
            for (int i = 0; i < 8; i++) begin
                m_tgt[k][i] = (i < m_n[k]) ? (INIT_T[i] + MOD) % MOD : 0;
                m_abs[k][i] = 1'b0;
            end
        end
    endfunction

    function automatic void model_step();
        int hh, ci;
        hh = int'(how_high);
        ci = int'(cfg_idx);
        for (int k = 0; k < 2; k++) begin
            if (m_st[k] == M_IDLE || m_st[k] == M_HALT) begin
                if (start) begin
                    m_st[k] = M_RUN; m_pc[k] = 0; m_bad[k] = 0; m_cnt[k] = 0;
                end
            end else if (halt) begin
                m_st[k] = M_HALT;
            end else if (advance) begin
                if (!branch_en) m_pc[k] = (m_pc[k] + 1) % MOD;
                else if (hh < m_n[k]) begin
                    if (m_abs[k][hh]) m_pc[k] = m_tgt[k][hh];
                    else m_pc[k] = (m_pc[k] + m_tgt[k][hh]) % MOD;
                    if (CNT_EN && m_cnt[k] < 65535) m_cnt[k]++;
                end else m_bad[k] = 1;
            end
            if (cfg_we && ci < m_n[k]) begin
                m_tgt[k][ci] = int'(cfg_data);
                m_abs[k][ci] = cfg_abs;
            end
        end
    endfunction

    task automatic compare_all();
        check("n8.pc",   int'(pc8),   m_pc[0]);
        check("n8.run",  int'(run8),  int'(m_st[0] == M_RUN));
        check("n8.done", int'(done8), int'(m_st[0] == M_HALT));
        check("n8.bad",  int'(bad8),  m_bad[0]);
        check("n8.cnt",  int'(cnt8),  m_cnt[0]);
        check("n6.pc",   int'(pc6),   m_pc[1]);
        check("n6.run",  int'(run6),  int'(m_st[1] == M_RUN));
        check("n6.done", int'(done6), int'(m_st[1] == M_HALT));
        check("n6.bad",  int'(bad6),  m_bad[1]);
        check("n6.cnt",  int'(cnt6),  m_cnt[1]);
    endtask

    task automatic drive(input bit st, input bit hl, input bit adv, input bit br, input int hh,
                         input bit we, input int ci, input int cd, input bit ca);
        start = st; halt = hl; advance = adv; branch_en = br; how_high = 3'(hh);
        cfg_we = we; cfg_idx = 3'(ci); cfg_data = 12'(cd); cfg_abs = ca;
    endtask

    task automatic step();
        model_step();
        @(posedge Clk);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic reset_mid();
        Reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        compare_all();
        check("rst.pc", int'(pc8), 0);
        check("rst.run", int'(run8), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("start.pc", int'(pc8), 0);
        check("start.run", int'(run8), 1);
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step();
            check("adv.pc", int'(pc8), i);
        end
        check("adv.done", int'(done8), 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 3, 0, 0, 0, 0); step();
        check("rel.wrap", int'(pc8), 4074);

        drive(0, 0, 0, 0, 0, 1, 5, 'h100, 1); step();
        check("hold.pc", int'(pc8), 4074);
        drive(0, 0, 1, 1, 5, 0, 0, 0, 0); step();
        check("abs.pc", int'(pc8), 256);

        drive(0, 0, 0, 0, 0, 1, 1, 10, 1); step();
        drive(0, 0, 1, 1, 1, 0, 0, 0, 0); step();
        check("abs10.pc", int'(pc8), 10);
        drive(0, 0, 1, 1, 2, 1, 2, 7, 0); step();
        check("collide.old", int'(pc8), 32);
        drive(0, 0, 1, 1, 2, 0, 0, 0, 0); step();
        check("collide.new", int'(pc8), 39);

        drive(0, 0, 0, 0, 0, 1, 4, 4095, 1); step();
        drive(0, 0, 1, 1, 4, 0, 0, 0, 0); step();
        check("pc4095", int'(pc8), 4095);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step();
        check("inc.wrap", int'(pc8), 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0, 0); step();
        check("halt.done", int'(done8), 1);
        check("halt.pc", int'(pc8), 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step();
        check("halted.hold", int'(pc8), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("restart.run", int'(run8), 1);

        drive(0, 0, 1, 1, 7, 0, 0, 0, 0); step();
        check("bad.flag", int'(bad6), 1);
        check("bad.hold", int'(pc6), 0);
        check("n8.idx7", int'(pc8), 3928);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0); step();
        check("bad.sticky", int'(bad6), 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0, 0, 0, 0, 0); step();
        end
        check("taken3", int'(cnt6), CNT_EN ? 3 : 0);
        check("pc6.after", int'(pc6), 7);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check("clr.bad", int'(bad6), 0);
        check("clr.cnt", int'(cnt6), 0);

        drive(0, 0, 1, 0, 0, 1, 3, 55, 1); step();
        reset_mid();
        check("mid.pc", int'(pc8), 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(0, 0, 1, 1, 3, 0, 0, 0, 0); step();
        check("tbl.restored", int'(pc8), 4070);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_mid();
            end else begin
                drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4,
                      $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                      int'($urandom_range(0, 7)), $urandom_range(0, 99) < 20,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)),
                      $urandom_range(0, 1) == 1);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
